// File: rtl/tcap_pkg.sv
// Shared types and constants for the tcap capture sequencer.
package tcap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_TRIG,
      ST_WAIT_RDY,
      ST_STREAM,
      ST_CMPT,
      ST_NEXT
   } tcap_state_t;

   // Cycles the capture config is held stable before each trigger.
   localparam int ARM_SETTLE = 4;

   localparam int TOP0_0_DEF = 3;
   localparam int LDD0_0_DEF = 32;
   localparam int ADC0_1_DEF = 56;
   localparam int ADC0_2_DEF = 2;
   localparam int BEAT_W_DEF = 16;
   localparam int CNT_W_DEF  = 8;
   localparam int TMO_W_DEF  = 20;

endpackage

// File: rtl/tcap_beat_cnt.sv
// Beats-remaining down-counter with last-beat flag, plus the no-progress timeout.
// The timeout exists only when TCAP_TIMEOUT_EN is defined; otherwise tmo is tied low.
module tcap_beat_cnt
   import tcap_pkg::*;
#(
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int TMO_W  = TMO_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [BEAT_W-1:0] beats,
   input  logic              beat,
   input  logic              tmo_run,
   input  logic              tmo_restart,
   output logic              last,
   output logic              tmo
);

   logic [BEAT_W-1:0] beat_rem;

   // A programmed beat count of zero still moves one beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_rem <= '0;
      end else if (load) begin
         beat_rem <= (beats == '0) ? BEAT_W'(1) : beats;
      end else if (beat && (beat_rem != '0)) begin
         beat_rem <= beat_rem - 1'b1;
      end
   end

   assign last = (beat_rem == BEAT_W'(1));

`ifdef TCAP_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt;

   // Reloads while idle, on state entry and on every beat; expires at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '1;
      end else if (!tmo_run || tmo_restart) begin
         tmo_cnt <= '1;
      end else if (tmo_cnt != '0) begin
         tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   assign tmo = tmo_run && (tmo_cnt == '0);
`else
   logic [TMO_W-1:0] unused_tmo;
   assign unused_tmo = {TMO_W{tmo_run ^ tmo_restart}};
   assign tmo        = 1'b0;
`endif

endmodule

// File: rtl/tcap_seq_ctrl.sv
// Capture sequencer: runs a programmed burst of ADC captures through the CDC capture path.
// Define TCAP_TIMEOUT_EN to abort a capture that makes no progress in WAIT_RDY/STREAM.
//
// state       | meaning
// ST_IDLE     | waiting for cmd_start
// ST_ARM      | config driven, settling across the CDC
// ST_TRIG     | one-cycle capture trigger
// ST_WAIT_RDY | waiting for the capture path to report ready
// ST_STREAM   | draining merged beats to the sink
// ST_CMPT     | one-cycle capture-complete pulse
// ST_NEXT     | advance phase, start next capture or finish
module tcap_seq_ctrl
   import tcap_pkg::*;
#(
   parameter int TOP0_0 = TOP0_0_DEF,
   parameter int LDD0_0 = LDD0_0_DEF,
   parameter int ADC0_1 = ADC0_1_DEF,
   parameter int ADC0_2 = ADC0_2_DEF,
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int TMO_W  = TMO_W_DEF
) (
   input  logic              Gc_clk125,
   input  logic              Gc_rst,
   input  logic              cmd_start,
   input  logic              cmd_abort,
   input  logic              cmd_mode,
   input  logic [TOP0_0-1:0] cmd_wdis,
   input  logic [LDD0_0-1:0] cmd_plus,
   input  logic [BEAT_W-1:0] cmd_beats,
   input  logic [CNT_W-1:0]  cmd_count,
   input  logic [ADC0_2-1:0] cmd_phase,
   output logic              Gc_cap_mode,
   output logic [TOP0_0-1:0] Gc_cap_wdis,
   output logic [LDD0_0-1:0] Gc_cap_plus,
   output logic              Gc_cap_trig,
   input  logic              Gc_capr_rdy,
   output logic              Gc_cap_cmpt,
   output logic [ADC0_2-1:0] Gc_cap_phase,
   input  logic [ADC0_1-1:0] Gc_merge_data,
   input  logic              Gc_mereg_datv,
   output logic              Gc_mereg_datr,
   output logic [ADC0_1-1:0] o_data,
   output logic              o_datv,
   output logic              o_last,
   input  logic              i_datr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   tcap_state_t       state, state_nxt;
   logic [2:0]        arm_cnt;
   logic [CNT_W-1:0]  caps_rem;
   logic [BEAT_W-1:0] beats_q;
   logic              in_stream, abort_any, start_ok, beat, last_beat, tmo;
   logic              done_set, err_set, beat_load, tmo_run, tmo_restart;

   assign in_stream = (state == ST_STREAM);
   assign start_ok  = (state == ST_IDLE) && cmd_start;
   assign abort_any = (state != ST_IDLE) && (cmd_abort || tmo);

   assign Gc_mereg_datr = in_stream && !abort_any && i_datr;
   assign o_datv        = in_stream && !abort_any && Gc_mereg_datv;
   assign o_data        = in_stream ? Gc_merge_data : '0;
   assign beat          = o_datv && i_datr;
   assign o_last        = o_datv && last_beat;

   assign Gc_cap_trig = (state == ST_TRIG) && !abort_any;
   assign Gc_cap_cmpt = (state == ST_CMPT) && !abort_any;
   assign busy        = (state != ST_IDLE);

   assign beat_load   = !in_stream;
   assign tmo_run     = (state == ST_WAIT_RDY) || in_stream;
   assign tmo_restart = beat || ((state == ST_WAIT_RDY) && Gc_capr_rdy);

   tcap_beat_cnt #(
      .BEAT_W (BEAT_W),
      .TMO_W  (TMO_W)
   ) u_beat_cnt (
      .clk         (Gc_clk125),
      .rst         (Gc_rst),
      .load        (beat_load),
      .beats       (beats_q),
      .beat        (beat),
      .tmo_run     (tmo_run),
      .tmo_restart (tmo_restart),
      .last        (last_beat),
      .tmo         (tmo)
   );

   always_ff @(posedge Gc_clk125 or posedge Gc_rst) begin
      if (Gc_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      done_set  = 1'b0;
      err_set   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_start) begin
               if (cmd_count == '0) done_set  = 1'b1;
               else                 state_nxt = ST_ARM;
            end
         end
         ST_ARM:      if (arm_cnt == '0) state_nxt = ST_TRIG;
         ST_TRIG:     state_nxt = ST_WAIT_RDY;
         ST_WAIT_RDY: if (Gc_capr_rdy) state_nxt = ST_STREAM;
         ST_STREAM:   if (beat && last_beat) state_nxt = ST_CMPT;
         ST_CMPT:     state_nxt = ST_NEXT;
         ST_NEXT: begin
            if (caps_rem != '0) begin
               state_nxt = ST_ARM;
            end else begin
               state_nxt = ST_IDLE;
               done_set  = 1'b1;
            end
         end
         default:     state_nxt = ST_IDLE;
      endcase
      if (abort_any) begin
         state_nxt = ST_IDLE;
         done_set  = 1'b1;
         err_set   = 1'b1;
      end
   end

   // First ARM after a start runs one extra cycle while the config registers load.
   always_ff @(posedge Gc_clk125 or posedge Gc_rst) begin
      if (Gc_rst) begin
         done         <= 1'b0;
         err          <= 1'b0;
         arm_cnt      <= '0;
         caps_rem     <= '0;
         beats_q      <= '0;
         Gc_cap_mode  <= 1'b0;
         Gc_cap_wdis  <= '0;
         Gc_cap_plus  <= '0;
         Gc_cap_phase <= '0;
      end else begin
         done <= done_set;
         if (start_ok) begin
            err          <= 1'b0;
            arm_cnt      <= 3'(ARM_SETTLE);
            caps_rem     <= cmd_count;
            beats_q      <= cmd_beats;
            Gc_cap_mode  <= cmd_mode;
            Gc_cap_wdis  <= cmd_wdis;
            Gc_cap_plus  <= cmd_plus;
            Gc_cap_phase <= cmd_phase;
         end else begin
            if (err_set) err <= 1'b1;
            if ((state == ST_ARM) && (arm_cnt != '0)) arm_cnt <= arm_cnt - 1'b1;
            if (!abort_any && (state == ST_CMPT)) caps_rem <= caps_rem - 1'b1;
            if (!abort_any && (state == ST_NEXT)) begin
               Gc_cap_phase <= Gc_cap_phase + 1'b1;
               arm_cnt      <= 3'(ARM_SETTLE - 1);
            end
         end
      end
   end

endmodule

// File: tb/tb_tcap_seq_ctrl.sv
// Self-checking bench for tcap_seq_ctrl: timeline model of the burst sequence plus directed scenarios.
module tb_tcap_seq_ctrl;

   localparam int TOP0_0 = 3;
   localparam int LDD0_0 = 32;
   localparam int ADC0_1 = 56;
   localparam int ADC0_2 = 2;
   localparam int BEAT_W = 16;
   localparam int CNT_W  = 8;
   localparam int TMO_W  = 4;

   logic              Gc_clk125 = 1'b0;
   logic              Gc_rst = 1'b1;
   logic              cmd_start = 1'b0, cmd_abort = 1'b0, cmd_mode = 1'b0;
   logic [TOP0_0-1:0] cmd_wdis = '0;
   logic [LDD0_0-1:0] cmd_plus = '0;
   logic [BEAT_W-1:0] cmd_beats = '0;
   logic [CNT_W-1:0]  cmd_count = '0;
   logic [ADC0_2-1:0] cmd_phase = '0;
   logic              Gc_cap_mode, Gc_cap_trig, Gc_cap_cmpt;
   logic [TOP0_0-1:0] Gc_cap_wdis;
   logic [LDD0_0-1:0] Gc_cap_plus;
   logic              Gc_capr_rdy = 1'b1;
   logic [ADC0_2-1:0] Gc_cap_phase;
   logic [ADC0_1-1:0] Gc_merge_data = '0;
   logic              Gc_mereg_datv = 1'b1;
   logic              Gc_mereg_datr;
   logic [ADC0_1-1:0] o_data;
   logic              o_datv, o_last;
   logic              i_datr = 1'b1;
   logic              busy, done, err;

   always #5 Gc_clk125 = ~Gc_clk125;

   tcap_seq_ctrl #(
      .TOP0_0(TOP0_0), .LDD0_0(LDD0_0), .ADC0_1(ADC0_1), .ADC0_2(ADC0_2),
      .BEAT_W(BEAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)
   ) dut (
      .Gc_clk125(Gc_clk125), .Gc_rst(Gc_rst),
      .cmd_start(cmd_start), .cmd_abort(cmd_abort), .cmd_mode(cmd_mode),
      .cmd_wdis(cmd_wdis), .cmd_plus(cmd_plus), .cmd_beats(cmd_beats),
      .cmd_count(cmd_count), .cmd_phase(cmd_phase),
      .Gc_cap_mode(Gc_cap_mode), .Gc_cap_wdis(Gc_cap_wdis), .Gc_cap_plus(Gc_cap_plus),
      .Gc_cap_trig(Gc_cap_trig), .Gc_capr_rdy(Gc_capr_rdy), .Gc_cap_cmpt(Gc_cap_cmpt),
      .Gc_cap_phase(Gc_cap_phase), .Gc_merge_data(Gc_merge_data),
      .Gc_mereg_datv(Gc_mereg_datv), .Gc_mereg_datr(Gc_mereg_datr),
      .o_data(o_data), .o_datv(o_datv), .o_last(o_last), .i_datr(i_datr),
      .busy(busy), .done(done), .err(err)
   );

   int n_tot = 0, n_bad = 0;
   int cyc = 0;

   // model: expected events placed on an absolute cycle timeline
   bit    m_busy, m_err, m_mode, rdy_wait, stream_on;
   int    m_phase, m_wdis, beats_left, beats_cfg, caps_left, quiet;
   longint m_plus;
   int    trig_at = -1, cmpt_at = -1, done_at = -1, phase_at = -1;

   // observed-event statistics
   int n_trig, n_cmpt, n_done, n_xfer, n_last, n_busycyc;
   int start_cyc, trig_cyc, cmpt_cyc, done_cyc, last_gap;
   int trig_ph[$];

   bit datv_gap = 1'b0, datr_toggle = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_err = 0; m_mode = 0; rdy_wait = 0; stream_on = 0;
      m_phase = 0; m_wdis = 0; m_plus = 0; beats_left = 0; caps_left = 0; quiet = 0;
      trig_at = -1; cmpt_at = -1; done_at = -1; phase_at = -1;
   endtask

   task automatic cmp_cycle();
      bit ab, tmo_now, e_str, e_datv, e_datr, e_last;
      logic [ADC0_1-1:0] e_data;
      cyc++;
      if (Gc_rst) begin
         chk("rst_ctrl", 64'({Gc_cap_trig, Gc_cap_cmpt, done, busy, err, Gc_mereg_datr, o_datv, o_last}), 64'(0));
         chk("rst_cfg_phase", 64'({Gc_cap_mode, Gc_cap_wdis, Gc_cap_plus, Gc_cap_phase}), 64'(0));
         chk("rst_data", 64'(o_data), 64'(0));
         model_reset();
         return;
      end
      if (cyc == done_at) m_busy = 0;
      if (cyc == phase_at) m_phase = (m_phase + 1) % (1 << ADC0_2);
      tmo_now = 0;
`ifdef TCAP_TIMEOUT_EN
      tmo_now = (rdy_wait || stream_on) && (quiet == (1 << TMO_W) - 1);
`endif
      ab     = m_busy && (cmd_abort || tmo_now);
      e_str  = stream_on && !ab;
      e_datv = e_str && Gc_mereg_datv;
      e_datr = e_str && i_datr;
      e_last = e_datv && (beats_left == 1);
      e_data = stream_on ? Gc_merge_data : '0;
      chk("ctrl{trig,cmpt,done,busy,err,datr,datv,last}",
          64'({Gc_cap_trig, Gc_cap_cmpt, done, busy, err, Gc_mereg_datr, o_datv, o_last}),
          64'({(cyc == trig_at) && !ab, (cyc == cmpt_at) && !ab, cyc == done_at, m_busy, m_err,
               e_datr, e_datv, e_last}));
      chk("cfg", 64'({Gc_cap_mode, Gc_cap_wdis, Gc_cap_plus}), 64'({m_mode, 3'(m_wdis), 32'(m_plus)}));
      chk("phase", 64'(Gc_cap_phase), 64'(m_phase));
      chk("o_data", 64'(o_data), 64'(e_data));

      if (Gc_cap_trig) begin
         n_trig++; trig_cyc = cyc; last_gap = cyc - cmpt_cyc; trig_ph.push_back(int'(Gc_cap_phase));
      end
      if (Gc_cap_cmpt) begin n_cmpt++; cmpt_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (o_datv && i_datr) n_xfer++;
      if (o_datv && i_datr && o_last) n_last++;
      if (busy) n_busycyc++;

      if (!m_busy) begin
         if (cmd_start) begin
            start_cyc = cyc; m_err = 0; m_phase = int'(cmd_phase);
            m_mode = cmd_mode; m_wdis = int'(cmd_wdis); m_plus = longint'(cmd_plus);
            caps_left = int'(cmd_count);
            beats_cfg = (cmd_beats == 0) ? 1 : int'(cmd_beats);
            if (cmd_count == 0) done_at = cyc + 1;
            else begin m_busy = 1; trig_at = cyc + 6; end
         end
      end else if (ab) begin
         m_err = 1; m_busy = 0; done_at = cyc + 1;
         trig_at = -1; cmpt_at = -1; phase_at = -1; rdy_wait = 0; stream_on = 0;
      end else begin
         if (stream_on) begin
            quiet++;
            if (e_datv && i_datr) begin
               quiet = 0; beats_left--;
               if (beats_left == 0) begin stream_on = 0; cmpt_at = cyc + 1; end
            end
         end else if (rdy_wait) begin
            quiet++;
            if (Gc_capr_rdy) begin rdy_wait = 0; stream_on = 1; beats_left = beats_cfg; quiet = 0; end
         end
         if (cyc == trig_at) begin rdy_wait = 1; quiet = 0; end
         if (cyc == cmpt_at) begin
            caps_left--; phase_at = cyc + 2;
            if (caps_left > 0) trig_at = cyc + 6;
            else done_at = cyc + 2;
         end
      end
   endtask

   task automatic step();
      @(negedge Gc_clk125);
      cmp_cycle();
      @(posedge Gc_clk125);
      #1;
      Gc_merge_data = ADC0_1'({$urandom, $urandom});
      Gc_mereg_datv = datv_gap ? ((cyc % 3) != 0) : 1'b1;
      if (datr_toggle) i_datr = ~i_datr;
   endtask

   task automatic start_burst(input int cnt, input int bts, input int ph, input bit md,
                              input int wd, input longint pl);
      cmd_count = CNT_W'(cnt); cmd_beats = BEAT_W'(bts); cmd_phase = ADC0_2'(ph);
      cmd_mode = md; cmd_wdis = TOP0_0'(wd); cmd_plus = LDD0_0'(pl);
      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string nm);
      int base = n_done;
      for (int i = 0; i < budget; i++) begin
         if (n_done != base) return;
         step();
      end
      if (n_done == base) begin
         n_tot++; n_bad++;
         $display("FAIL %s: no done within %0d cycles", nm, budget);
      end
   endtask

   initial begin
      int b_trig, b_cmpt, b_done, b_xfer, b_last, b_busy;
      model_reset();
      repeat (3) step();
      Gc_rst = 1'b0;
      step();
      chk("reset_phase", 64'(Gc_cap_phase), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));

      // single capture
      b_xfer = n_xfer; b_last = n_last; b_cmpt = n_cmpt;
      start_burst(1, 4, 2, 1'b1, 5, 64'hdead_beef);
      wait_done(100, "single_done");
      chk("single_trig_lat", 64'(trig_cyc - start_cyc), 64'(6));
      chk("single_done_lat", 64'(done_cyc - start_cyc), 64'(14));
      chk("single_xfer", 64'(n_xfer - b_xfer), 64'(4));
      chk("single_last", 64'(n_last - b_last), 64'(1));
      chk("single_cmpt", 64'(n_cmpt - b_cmpt), 64'(1));
      chk("single_phase", 64'(Gc_cap_phase), 64'(3));
      chk("single_cfg", 64'({Gc_cap_mode, Gc_cap_wdis, Gc_cap_plus}), 64'({1'b1, 3'd5, 32'hdead_beef}));

      // burst of three, beats=0 behaves as one beat; a start mid-burst is ignored
      step();
      b_trig = n_trig; b_cmpt = n_cmpt; b_done = n_done; b_xfer = n_xfer;
      trig_ph.delete();
      start_burst(3, 0, 3, 1'b0, 2, 64'h1234);
      repeat (10) step();
      cmd_count = '0;
      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      wait_done(300, "burst_done");
      repeat (2) step();
      chk("burst_trigs", 64'(n_trig - b_trig), 64'(3));
      chk("burst_cmpts", 64'(n_cmpt - b_cmpt), 64'(3));
      chk("burst_dones", 64'(n_done - b_done), 64'(1));
      chk("burst_xfer", 64'(n_xfer - b_xfer), 64'(3));
      chk("burst_cmpt_to_trig", 64'(last_gap), 64'(6));
      if (trig_ph.size() == 3) begin
         chk("burst_ph0", 64'(trig_ph[0]), 64'(3));
         chk("burst_ph1", 64'(trig_ph[1]), 64'(0));
         chk("burst_ph2", 64'(trig_ph[2]), 64'(1));
      end else begin
         n_tot++; n_bad++;
         $display("FAIL burst_ph_count: got %0d expected 3", trig_ph.size());
      end
      chk("burst_phase_end", 64'(Gc_cap_phase), 64'(2));

      // sink backpressure and gapped valid
      b_xfer = n_xfer; b_last = n_last;
      datv_gap = 1'b1; datr_toggle = 1'b1;
      start_burst(1, 5, 0, 1'b0, 1, 64'h55);
      wait_done(200, "bp_done");
      datv_gap = 1'b0; datr_toggle = 1'b0; i_datr = 1'b1; Gc_mereg_datv = 1'b1;
      chk("bp_xfer", 64'(n_xfer - b_xfer), 64'(5));
      chk("bp_last", 64'(n_last - b_last), 64'(1));

      // zero-capture burst
      step();
      b_trig = n_trig; b_busy = n_busycyc;
      start_burst(0, 4, 1, 1'b0, 0, 64'h0);
      wait_done(5, "zero_done");
      step();
      chk("zero_done_lat", 64'(done_cyc - start_cyc), 64'(1));
      chk("zero_trigs", 64'(n_trig - b_trig), 64'(0));
      chk("zero_busy", 64'(n_busycyc - b_busy), 64'(0));

      // abort mid-stream
      b_cmpt = n_cmpt; b_done = n_done; b_xfer = n_xfer;
      start_burst(2, 8, 1, 1'b0, 3, 64'h77);
      for (int i = 0; i < 100 && (n_xfer - b_xfer) < 3; i++) step();
      cmd_abort = 1'b1;
      step();
      cmd_abort = 1'b0;
      wait_done(5, "abort_done");
      chk("abort_err", 64'(err), 64'(1));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_cmpt", 64'(n_cmpt - b_cmpt), 64'(0));
      chk("abort_dones", 64'(n_done - b_done), 64'(1));
      chk("abort_xfer", 64'(n_xfer - b_xfer), 64'(3));
      start_burst(0, 1, 0, 1'b0, 0, 64'h0);
      chk("err_cleared", 64'(err), 64'(0));
      wait_done(5, "clear_done");

      // capture path never ready
      step();
      Gc_capr_rdy = 1'b0;
      b_done = n_done; b_cmpt = n_cmpt;
      start_burst(1, 2, 0, 1'b0, 0, 64'h9);
`ifdef TCAP_TIMEOUT_EN
      wait_done(200, "tmo_done");
      chk("tmo_lat", 64'(done_cyc - trig_cyc), 64'(17));
      chk("tmo_err", 64'(err), 64'(1));
`else
      repeat (1000) step();
      chk("notmo_busy", 64'(busy), 64'(1));
      chk("notmo_done", 64'(n_done - b_done), 64'(0));
      cmd_abort = 1'b1;
      step();
      cmd_abort = 1'b0;
      wait_done(5, "notmo_abort_done");
`endif
      chk("rdy_cmpt", 64'(n_cmpt - b_cmpt), 64'(0));
      Gc_capr_rdy = 1'b1;

      // reset in the middle of a stream
      step();
      b_done = n_done; b_cmpt = n_cmpt;
      start_burst(2, 6, 1, 1'b1, 4, 64'habc);
      repeat (9) step();
      Gc_rst = 1'b1;
      repeat (2) step();
      Gc_rst = 1'b0;
      repeat (3) step();
      chk("midrst_cmpt", 64'(n_cmpt - b_cmpt), 64'(0));
      chk("midrst_done", 64'(n_done - b_done), 64'(0));
      chk("midrst_phase", 64'(Gc_cap_phase), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
